// File: rtl/duty_display_driver.sv
// Converts the 8-bit duty value to BCD (double dabble, one shift per cycle) and
// scans it onto a 4-digit active-low 7-segment display with leading-zero blanking.
module duty_display_driver #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  value,
   output logic [11:0] bcd,
   output logic        busy,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  value_q;
   logic [7:0]  last_q;
   logic [19:0] shift_q;
   logic [19:0] shift_adj;
   logic [2:0]  count_q;
   logic        start;
   logic        shift_en;
   logic        load_en;

   logic [15:0] presc_q;
   logic [1:0]  idx_q;
   logic [1:0]  idx_next;
   logic        scan_wrap;
   logic [3:0]  digit_nib;
   logic        digit_blank;
   logic [6:0]  seg_next;

   function automatic logic [3:0] dabble(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Converter FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Converter FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (value_q != last_q) state_d = CONV;
         CONV:    if (count_q == 3'd7) state_d = LOAD;
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Converter FSM: outputs
   always_comb begin
      start    = 1'b0;
      shift_en = 1'b0;
      load_en  = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE: start = (value_q != last_q);
         CONV: begin
            shift_en = 1'b1;
            busy     = 1'b1;
         end
         LOAD: begin
            load_en = 1'b1;
            busy    = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   assign shift_adj = {dabble(shift_q[19:16]), dabble(shift_q[15:12]),
                       dabble(shift_q[11:8]), shift_q[7:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= 8'd0;
         last_q  <= 8'd0;
         shift_q <= 20'd0;
         count_q <= 3'd0;
         bcd     <= 12'h000;
      end else begin
         value_q <= value;
         if (start) begin
            shift_q <= {12'b0, value_q};
            last_q  <= value_q;
            count_q <= 3'd0;
         end else if (shift_en) begin
            shift_q <= {shift_adj[18:0], 1'b0};
            count_q <= count_q + 3'd1;
         end
         if (load_en) begin
            bcd <= shift_q[19:8];
         end
      end
   end

   assign scan_wrap = (presc_q == PRESC_MAX);
   assign idx_next  = idx_q + 2'd1;

   // Segment pattern for the digit about to be selected, using the latched bcd.
   always_comb begin
      digit_nib   = bcd[3:0];
      digit_blank = 1'b0;
      case (idx_next)
         2'd0: digit_nib = bcd[3:0];
         2'd1: begin
            digit_nib   = bcd[7:4];
            digit_blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
         end
         2'd2: begin
            digit_nib   = bcd[11:8];
            digit_blank = (bcd[11:8] == 4'd0);
         end
         default: digit_blank = 1'b1;
      endcase
      seg_next = digit_blank ? 7'h7F : seg_decode(digit_nib);
   end

   // an and seg move together, only on scan edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= 16'd0;
         idx_q   <= 2'd0;
         an      <= 4'b1110;
         seg     <= 7'h40;
      end else if (scan_wrap) begin
         presc_q <= 16'd0;
         idx_q   <= idx_next;
         an      <= ~(4'b0001 << idx_next);
         seg     <= seg_next;
      end else begin
         presc_q <= presc_q + 16'd1;
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_duty_display_driver.sv
// Directed + random bench for duty_display_driver with a decimal-arithmetic reference.
module tb_duty_display_driver;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  value;
   logic [11:0] bcd;
   logic        busy;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_v;

   duty_display_driver #(.REFRESH_DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .value (value),
      .bcd   (bcd),
      .busy  (busy),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   always #5 clk = ~clk;

   // Cycles since the last reset edge; digit k is selected during [k*DIV, (k+1)*DIV) mod frame.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] exp_bcd(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   function automatic logic [6:0] digit_seg(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return tbl[d];
   endfunction

   // Number printed right-aligned without leading zeros; position 0 is the ones digit.
   function automatic logic [6:0] exp_seg(input int v, input int pos);
      int ndig;
      int scale;
      ndig  = (v >= 100) ? 3 : ((v >= 10) ? 2 : 1);
      scale = (pos == 0) ? 1 : ((pos == 1) ? 10 : 100);
      if (pos >= ndig) return 7'h7F;
      return digit_seg((v / scale) % 10);
   endfunction

   task automatic check_frame(input int v);
      int pos;
      logic [3:0] e_an;
      repeat (4 * DIV) begin
         step();
         pos       = (cyc / DIV) % 4;
         e_an      = 4'b1111;
         e_an[pos] = 1'b0;
         chk("an", 32'(an), 32'(e_an));
         chk("seg", 32'(seg), 32'(exp_seg(v, pos)));
         chk("dp", 32'(dp), 32'd1);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_bcd", 32'(bcd), 32'(exp_bcd(v)));
      end
   endtask

   // Drive v and follow it edge by edge: capture at E0, busy E1..E9, bcd at E10.
   task automatic convert(input int v);
      value = 8'(v);
      step();
      chk("cap_busy", 32'(busy), 32'd0);
      for (int e = 1; e <= 9; e++) begin
         step();
         chk("conv_busy", 32'(busy), 32'd1);
         chk("conv_bcd_old", 32'(bcd), 32'(exp_bcd(last_v)));
      end
      step();
      chk("conv_bcd_new", 32'(bcd), 32'(exp_bcd(v)));
      chk("conv_busy_end", 32'(busy), 32'd0);
      last_v = v;
   endtask

   initial begin
      int v;
      int pulses;
      logic prev_busy;

      reset = 1'b1;
      value = 8'd0;
      repeat (3) step();
      chk("rst_bcd", 32'(bcd), 32'h000);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_an", 32'(an), 32'hE);
      chk("rst_seg", 32'(seg), 32'h40);
      chk("rst_dp", 32'(dp), 32'd1);
      reset  = 1'b0;
      last_v = 0;

      // value 0 after reset: no conversion, single "0" displayed
      check_frame(0);
      check_frame(0);

      convert(255);
      repeat (4 * DIV) step();
      check_frame(255);

      convert(7);
      repeat (4 * DIV) step();
      check_frame(7);

      convert(200);
      repeat (4 * DIV) step();
      check_frame(200);

      // 100 then 37 arriving mid-conversion: two clean results, nothing in between
      value = 8'd100;
      step();
      for (int e = 1; e <= 20; e++) begin
         step();
         if (e == 2) value = 8'd37;
         chk("ovl_busy", 32'(busy), ((e >= 1 && e <= 9) || (e >= 11 && e <= 19)) ? 32'd1 : 32'd0);
         chk("ovl_bcd", 32'(bcd),
             (e < 10) ? 32'(exp_bcd(200)) : ((e < 20) ? 32'(exp_bcd(100)) : 32'(exp_bcd(37))));
      end
      last_v = 37;
      repeat (4 * DIV) step();
      check_frame(37);

      // reset at E6 edge of a conversion of 180
      value = 8'd180;
      step();
      for (int e = 1; e <= 5; e++) step();
      reset = 1'b1;
      step();
      chk("mid_rst_bcd", 32'(bcd), 32'h000);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_an", 32'(an), 32'hE);
      chk("mid_rst_seg", 32'(seg), 32'h40);
      reset  = 1'b0;
      last_v = 0;
      convert(180);
      repeat (4 * DIV) step();
      check_frame(180);

      for (int k = 0; k < 5; k++) begin
         v = int'($urandom_range(0, 255));
         if (v == last_v) v = (v + 1) % 256;
         convert(v);
         repeat (4 * DIV) step();
         check_frame(v);
      end

      // steady input: one busy pulse over a long window
      v = int'($urandom_range(0, 255));
      if (v == last_v) v = (v + 1) % 256;
      value     = 8'(v);
      pulses    = 0;
      prev_busy = 1'b0;
      repeat (1000) begin
         step();
         if (busy && !prev_busy) pulses++;
         prev_busy = busy;
      end
      chk("hold_pulses", 32'(pulses), 32'd1);
      chk("hold_bcd", 32'(bcd), 32'(exp_bcd(v)));
      last_v = v;
      check_frame(v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
